// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-driven movement sequencer for the player sprite.
// On an accepted frame tick it computes a clamped candidate position and asks
// the shared collision checker about it through a valid/ready query and a
// response strobe. The candidate becomes the committed position only when the
// checker reports it is not blocked. All outputs come straight from registers.
module sprite_motion_ctrl #(
  parameter int STEP    = 2,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 470,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 460,
  parameter int START_X = 16,
  parameter int START_Y = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [2:0]  USER_INPUT,
  output logic        query_valid,
  output logic [8:0]  query_x,
  output logic [8:0]  query_y,
  input  logic        query_ready,
  input  logic        resp_valid,
  input  logic        resp_blocked,
  output logic [8:0]  pos_x,
  output logic [8:0]  pos_y,
  output logic        moved,
  output logic [15:0] move_count,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
  localparam logic [8:0]         TMO_END = 9'(TIMEOUT);

  state_e       state_q, state_d;
  logic [8:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [8:0]   query_x_q, query_x_d, query_y_q, query_y_d;
  logic         query_valid_q, query_valid_d;
  logic         moved_q, moved_d;
  logic [15:0]  move_count_q, move_count_d;
  logic         overrun_q, overrun_d;
  logic [7:0]   tmo_q, tmo_d;

  logic signed [10:0] dx, dy;
  logic               dir_ok;
  logic [8:0]         cand_x, cand_y;

  // Adds a signed step in 11 bits so a move past either edge can never wrap
  // around in 9 bits, then pins the result to the legal range.
  function automatic logic [8:0] clamp_axis(input logic [8:0]         cur,
                                            input logic signed [10:0] delta,
                                            input logic signed [10:0] lo,
                                            input logic signed [10:0] hi);
    logic signed [10:0] sum;
    sum = $signed({2'b00, cur}) + delta;
    if (sum < lo)      sum = lo;
    else if (sum > hi) sum = hi;
    return sum[8:0];
  endfunction

  // Decode the direction code and form the clamped candidate position.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    dx     = '0;
    dy     = '0;
    dir_ok = 1'b1;
    case (USER_INPUT)
      3'b001:  dy = -STEP_S;
      3'b010:  dx = -STEP_S;
      3'b100:  dy = STEP_S;
      3'b101:  dx = STEP_S;
      default: dir_ok = 1'b0;
    endcase
    cand_x = clamp_axis(pos_x_q, dx, X_MIN_S, X_MAX_S);
    cand_y = clamp_axis(pos_y_q, dy, Y_MIN_S, Y_MAX_S);
  end

  // Next-state and registered-output logic for the IDLE/REQ/WAIT sequencer.
  always_comb begin
    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    query_x_d     = query_x_q;
    query_y_d     = query_y_q;
    query_valid_d = query_valid_q;
    moved_d       = 1'b0;
    move_count_d  = move_count_q;
    overrun_d     = overrun_q;
    tmo_d         = tmo_q;

    // A tick that lands mid-transaction is dropped, but remembered forever.
    if (frame_tick && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_tick && dir_ok && ((cand_x != pos_x_q) || (cand_y != pos_y_q))) begin
          query_x_d     = cand_x;
          query_y_d     = cand_y;
          query_valid_d = 1'b1;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (query_valid_q && query_ready) begin
          query_valid_d = 1'b0;
          tmo_d         = '0;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 8'd1;
        // A response on the final cycle beats the timeout.
        if (resp_valid) begin
          if (!resp_blocked) begin
            pos_x_d = query_x_q;
            pos_y_d = query_y_q;
            moved_d = 1'b1;
            if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
          end
          state_d = S_IDLE;
        end else if ((9'(tmo_q) + 9'd1) == TMO_END) begin
          // Counter reaches TIMEOUT: give up, treat as blocked.
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      state_q       <= S_IDLE;
      pos_x_q       <= 9'(START_X);
      pos_y_q       <= 9'(START_Y);
      query_x_q     <= '0;
      query_y_q     <= '0;
      query_valid_q <= 1'b0;
      moved_q       <= 1'b0;
      move_count_q  <= '0;
      overrun_q     <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      query_x_q     <= query_x_d;
      query_y_q     <= query_y_d;
      query_valid_q <= query_valid_d;
      moved_q       <= moved_d;
      move_count_q  <= move_count_d;
      overrun_q     <= overrun_d;
      tmo_q         <= tmo_d;
    end
  end

  assign query_valid = query_valid_q;
  assign query_x     = query_x_q;
  assign query_y     = query_y_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign moved       = moved_q;
  assign move_count  = move_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl. A second instance starting at x = 1
// exercises the left-edge clamp; both instances share the stimulus.
module tb_sprite_motion_ctrl;

  logic        Clk, Reset, frame_tick, query_ready, resp_valid, resp_blocked;
  logic [2:0]  USER_INPUT;
  logic        query_valid, moved, overrun;
  logic [8:0]  query_x, query_y, pos_x, pos_y;
  logic [15:0] move_count;
  logic        b_query_valid, b_moved, b_overrun;
  logic [8:0]  b_query_x, b_query_y, b_pos_x, b_pos_y;
  logic [15:0] b_move_count;

  int checks = 0;
  int failures = 0;

  sprite_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .USER_INPUT(USER_INPUT),
    .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
    .query_ready(query_ready), .resp_valid(resp_valid), .resp_blocked(resp_blocked),
    .pos_x(pos_x), .pos_y(pos_y), .moved(moved), .move_count(move_count),
    .overrun(overrun)
  );

  sprite_motion_ctrl #(.START_X(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .USER_INPUT(USER_INPUT),
    .query_valid(b_query_valid), .query_x(b_query_x), .query_y(b_query_y),
    .query_ready(query_ready), .resp_valid(resp_valid), .resp_blocked(resp_blocked),
    .pos_x(b_pos_x), .pos_y(b_pos_y), .moved(b_moved), .move_count(b_move_count),
    .overrun(b_overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    frame_tick = 1'b0; USER_INPUT = 3'b000;
    query_ready = 1'b0; resp_valid = 1'b0; resp_blocked = 1'b0;
    #2;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (pos_x !== 9'd16) begin failures++; $display("FAIL reset_pos_x got=%0d exp=16", pos_x); end
    checks++; if (pos_y !== 9'd16) begin failures++; $display("FAIL reset_pos_y got=%0d exp=16", pos_y); end
    checks++; if (query_valid !== 1'b0) begin failures++; $display("FAIL reset_query_valid got=%b exp=0", query_valid); end
    checks++; if ({query_x, query_y} !== 18'd0) begin failures++; $display("FAIL reset_query_xy got=%0d,%0d exp=0,0", query_x, query_y); end
    checks++; if ({moved, overrun} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", moved, overrun); end
    checks++; if (move_count !== 16'd0) begin failures++; $display("FAIL reset_move_count got=%0d exp=0", move_count); end
    checks++; if (b_pos_x !== 9'd1) begin failures++; $display("FAIL reset_b_pos_x got=%0d exp=1", b_pos_x); end
  endtask

  task automatic test_move_right();
    frame_tick = 1'b1; USER_INPUT = 3'b101; query_ready = 1'b1;
    step();
    frame_tick = 1'b0; USER_INPUT = 3'b010;  // must not affect the transaction
    checks++; if (query_valid !== 1'b1) begin failures++; $display("FAIL right_query_valid got=%b exp=1", query_valid); end
    checks++; if (query_x !== 9'd18 || query_y !== 9'd16) begin failures++; $display("FAIL right_query_xy got=%0d,%0d exp=18,16", query_x, query_y); end
    checks++; if (pos_x !== 9'd16) begin failures++; $display("FAIL right_pos_early got=%0d exp=16", pos_x); end
    step();
    checks++; if (query_valid !== 1'b0) begin failures++; $display("FAIL right_valid_drop got=%b exp=0", query_valid); end
    query_ready = 1'b0; resp_valid = 1'b1; resp_blocked = 1'b0;
    step();
    resp_valid = 1'b0;
    checks++; if (pos_x !== 9'd18 || pos_y !== 9'd16) begin failures++; $display("FAIL right_pos got=%0d,%0d exp=18,16", pos_x, pos_y); end
    checks++; if (moved !== 1'b1) begin failures++; $display("FAIL right_moved got=%b exp=1", moved); end
    checks++; if (move_count !== 16'd1) begin failures++; $display("FAIL right_count got=%0d exp=1", move_count); end
    step();
    checks++; if (moved !== 1'b0) begin failures++; $display("FAIL right_moved_pulse got=%b exp=0", moved); end
    checks++; if (pos_x !== 9'd18 || move_count !== 16'd1) begin failures++; $display("FAIL right_hold got=%0d/%0d exp=18/1", pos_x, move_count); end
  endtask

  task automatic test_blocked();
    apply_reset();
    frame_tick = 1'b1; USER_INPUT = 3'b001; query_ready = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++; if (query_x !== 9'd16 || query_y !== 9'd14) begin failures++; $display("FAIL up_query_xy got=%0d,%0d exp=16,14", query_x, query_y); end
    step();
    query_ready = 1'b0; resp_valid = 1'b1; resp_blocked = 1'b1;
    step();
    resp_valid = 1'b0; resp_blocked = 1'b0;
    checks++; if (pos_x !== 9'd16 || pos_y !== 9'd16) begin failures++; $display("FAIL blocked_pos got=%0d,%0d exp=16,16", pos_x, pos_y); end
    checks++; if (moved !== 1'b0) begin failures++; $display("FAIL blocked_moved got=%b exp=0", moved); end
    checks++; if (move_count !== 16'd0) begin failures++; $display("FAIL blocked_count got=%0d exp=0", move_count); end
    step();
    checks++; if (moved !== 1'b0 || query_valid !== 1'b0) begin failures++; $display("FAIL blocked_idle got=%b%b exp=00", moved, query_valid); end
  endtask

  task automatic test_clamp();
    apply_reset();
    frame_tick = 1'b1; USER_INPUT = 3'b010; query_ready = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++; if (b_query_valid !== 1'b1) begin failures++; $display("FAIL clamp_query_valid got=%b exp=1", b_query_valid); end
    checks++; if (b_query_x !== 9'd0 || b_query_y !== 9'd16) begin failures++; $display("FAIL clamp_query_xy got=%0d,%0d exp=0,16", b_query_x, b_query_y); end
    checks++; if (query_x !== 9'd14) begin failures++; $display("FAIL left_query_x got=%0d exp=14", query_x); end
    step();
    resp_valid = 1'b1; resp_blocked = 1'b0;
    step();
    resp_valid = 1'b0;
    checks++; if (b_pos_x !== 9'd0 || b_moved !== 1'b1) begin failures++; $display("FAIL clamp_commit got=%0d/%b exp=0/1", b_pos_x, b_moved); end
    step();
    // At the left edge another left move yields no change: no query.
    frame_tick = 1'b1; USER_INPUT = 3'b010;
    step();
    frame_tick = 1'b0;
    checks++; if (b_query_valid !== 1'b0) begin failures++; $display("FAIL edge_no_query got=%b exp=0", b_query_valid); end
    step();
    checks++; if (b_query_valid !== 1'b0) begin failures++; $display("FAIL edge_no_query_2 got=%b exp=0", b_query_valid); end
    resp_valid = 1'b1; resp_blocked = 1'b0;
    step();
    resp_valid = 1'b0;
    checks++; if (b_pos_x !== 9'd0 || b_moved !== 1'b0 || b_move_count !== 16'd1) begin failures++; $display("FAIL edge_resp_ignored got=%0d/%b/%0d exp=0/0/1", b_pos_x, b_moved, b_move_count); end
    checks++; if (pos_x !== 9'd12 || move_count !== 16'd2) begin failures++; $display("FAIL left_twice got=%0d/%0d exp=12/2", pos_x, move_count); end
    query_ready = 1'b0;
  endtask

  task automatic test_invalid();
    logic [2:0] codes [4] = '{3'b111, 3'b000, 3'b011, 3'b110};
    apply_reset();
    query_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1; USER_INPUT = codes[i];
      step();
      frame_tick = 1'b0;
      checks++; if (query_valid !== 1'b0) begin failures++; $display("FAIL invalid_code_%0d query_valid got=%b exp=0", i, query_valid); end
    end
    resp_valid = 1'b1; resp_blocked = 1'b0;
    step();
    resp_valid = 1'b0;
    checks++; if (pos_x !== 9'd16 || pos_y !== 9'd16 || moved !== 1'b0) begin failures++; $display("FAIL idle_resp_ignored got=%0d,%0d/%b exp=16,16/0", pos_x, pos_y, moved); end
    frame_tick = 1'b1; USER_INPUT = 3'b100;
    step();
    frame_tick = 1'b0;
    checks++; if (query_valid !== 1'b1 || query_x !== 9'd16 || query_y !== 9'd18) begin failures++; $display("FAIL down_after_invalid got=%b %0d,%0d exp=1 16,18", query_valid, query_x, query_y); end
    step();
    query_ready = 1'b0; resp_valid = 1'b1; resp_blocked = 1'b1;
    step();
    resp_valid = 1'b0; resp_blocked = 1'b0;
  endtask

  task automatic test_stall_overrun();
    apply_reset();
    query_ready = 1'b0;
    frame_tick = 1'b1; USER_INPUT = 3'b100;
    step();
    frame_tick = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL idle_tick_overrun got=%b exp=0", overrun); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin frame_tick = 1'b1; USER_INPUT = 3'b101; end
      step();
      frame_tick = 1'b0;
      checks++; if (query_valid !== 1'b1 || query_x !== 9'd16 || query_y !== 9'd18) begin failures++; $display("FAIL stall_%0d got=%b %0d,%0d exp=1 16,18", i, query_valid, query_x, query_y); end
      if (i == 2) begin
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
      end
    end
    query_ready = 1'b1;
    step();
    query_ready = 1'b0; resp_valid = 1'b1; resp_blocked = 1'b0;
    step();
    resp_valid = 1'b0;
    checks++; if (pos_x !== 9'd16 || pos_y !== 9'd18 || move_count !== 16'd1) begin failures++; $display("FAIL stall_commit got=%0d,%0d/%0d exp=16,18/1", pos_x, pos_y, move_count); end
    step();
    step();
    checks++; if (query_valid !== 1'b0 || overrun !== 1'b1) begin failures++; $display("FAIL overrun_not_queued got=%b/%b exp=0/1", query_valid, overrun); end
  endtask

  // Continues from the stall scenario: pos (16,18), count 1, overrun set.
  task automatic test_timeout();
    query_ready = 1'b1; frame_tick = 1'b1; USER_INPUT = 3'b101;
    step();
    frame_tick = 1'b0;
    step();                       // transfer: WAIT, counter 0
    query_ready = 1'b0;
    repeat (255) step();          // counter reaches 255 on the last edge
    resp_valid = 1'b1; resp_blocked = 1'b0;
    step();
    resp_valid = 1'b0;
    checks++; if (pos_x !== 9'd16 || moved !== 1'b0 || move_count !== 16'd1) begin failures++; $display("FAIL timeout_blocked got=%0d/%b/%0d exp=16/0/1", pos_x, moved, move_count); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    // Response on the very edge the counter would reach TIMEOUT wins.
    query_ready = 1'b1; frame_tick = 1'b1; USER_INPUT = 3'b101;
    step();
    frame_tick = 1'b0;
    step();
    query_ready = 1'b0;
    repeat (254) step();
    resp_valid = 1'b1; resp_blocked = 1'b0;
    step();
    resp_valid = 1'b0;
    checks++; if (pos_x !== 9'd18 || moved !== 1'b1 || move_count !== 16'd2) begin failures++; $display("FAIL timeout_edge_resp got=%0d/%b/%0d exp=18/1/2", pos_x, moved, move_count); end
  endtask

  task automatic test_reset_mid_wait();
    query_ready = 1'b1; frame_tick = 1'b1; USER_INPUT = 3'b100;
    step();
    frame_tick = 1'b0;
    step();
    query_ready = 1'b0;
    step();
    #2 Reset = 1'b1;
    #1;
    checks++; if (pos_x !== 9'd16 || pos_y !== 9'd16) begin failures++; $display("FAIL async_reset_pos got=%0d,%0d exp=16,16", pos_x, pos_y); end
    checks++; if ({query_valid, moved, overrun} !== 3'b000 || {query_x, query_y} !== 18'd0 || move_count !== 16'd0) begin failures++; $display("FAIL async_reset_outs got=%b%b%b %0d,%0d %0d exp=000 0,0 0", query_valid, moved, overrun, query_x, query_y, move_count); end
    step();
    Reset = 1'b0;
    frame_tick = 1'b1; USER_INPUT = 3'b101; query_ready = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++; if (query_valid !== 1'b1 || query_x !== 9'd18) begin failures++; $display("FAIL after_reset_query got=%b %0d exp=1 18", query_valid, query_x); end
    step();
    query_ready = 1'b0; resp_valid = 1'b1; resp_blocked = 1'b1;
    step();
    resp_valid = 1'b0; resp_blocked = 1'b0;
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_blocked();
    test_clamp();
    test_invalid();
    test_stall_overrun();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
